// File: rtl/dm_access_ctrl.sv
// M-stage data-memory access controller: alignment/range checks, handshaked memory port, stall and W-stage result registers.
// Optional bus timeout abort is enabled by defining DM_TIMEOUT_EN.
module dm_access_ctrl #(
    parameter logic [31:0] ADDR_LO = 32'h0000_0000,
    parameter logic [31:0] ADDR_HI = 32'h0000_2FFF,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_width,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] DM_RD,
    output logic [31:0] DM_A,
    output logic [1:0]  DM_Width_02,
    output logic        rd_valid,
    output logic        exc_adel,
    output logic        exc_ades
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("dm_access_ctrl: TIMEOUT must be at least 1");
    end

    state_t      state_q;
    logic        mem_req_q;
    logic [31:0] addr_q;
    logic [3:0]  byteen_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [1:0]  width_q;
    logic [31:0] dm_rd_q;
    logic [31:0] dm_a_q;
    logic [1:0]  dm_width_q;
    logic        rd_valid_q;
    logic        exc_adel_q;
    logic        exc_ades_q;

    logic        req_go;
    logic        req_legal;
    logic        aligned;
    logic        in_range;
    logic [3:0]  byteen_d;
    logic [31:0] wdata_d;

`ifdef DM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q;
`endif

    assign req_go = req_valid && !flush && (req_width != 2'd3);

    // Unsigned offset compare covers both bounds without a constant-true test when ADDR_LO is 0.
    assign in_range = (req_addr - ADDR_LO) <= (ADDR_HI - ADDR_LO);

    always_comb begin
        aligned = 1'b0;
        case (req_width)
            2'd0:    aligned = (req_addr[1:0] == 2'b00);
            2'd1:    aligned = !req_addr[0];
            2'd2:    aligned = 1'b1;
            default: aligned = 1'b0;
        endcase
    end

    assign req_legal = aligned && in_range;

    always_comb begin
        byteen_d = 4'b0000;
        wdata_d  = req_wdata;
        case (req_width)
            2'd0: byteen_d = 4'b1111;
            2'd1: begin
                byteen_d = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d  = {2{req_wdata[15:0]}};
            end
            2'd2: begin
                byteen_d = 4'b0001 << req_addr[1:0];
                wdata_d  = {4{req_wdata[7:0]}};
            end
            default: ;
        endcase
        if (!req_we) begin
            byteen_d = 4'b0000;
        end
    end

    always_comb begin
        stall = 1'b0;
        case (state_q)
            S_IDLE:   stall = req_go && req_legal;
            S_ACCESS: stall = 1'b1;
            S_DONE:   stall = 1'b0;
            S_DRAIN:  stall = req_valid;
            default:  stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            addr_q     <= '0;
            byteen_q   <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            width_q    <= '0;
            dm_rd_q    <= '0;
            dm_a_q     <= '0;
            dm_width_q <= '0;
            rd_valid_q <= 1'b0;
            exc_adel_q <= 1'b0;
            exc_ades_q <= 1'b0;
`ifdef DM_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            rd_valid_q <= 1'b0;
            exc_adel_q <= 1'b0;
            exc_ades_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_go && req_legal) begin
                        state_q   <= S_ACCESS;
                        mem_req_q <= 1'b1;
                        addr_q    <= req_addr;
                        byteen_q  <= byteen_d;
                        wdata_q   <= wdata_d;
                        we_q      <= req_we;
                        width_q   <= req_width;
`ifdef DM_TIMEOUT_EN
                        cnt_q     <= '0;
`endif
                    end else if (req_go) begin
                        exc_adel_q <= !req_we;
                        exc_ades_q <= req_we;
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (flush) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q    <= S_DONE;
                            dm_a_q     <= addr_q;
                            dm_width_q <= width_q;
                            if (!we_q) begin
                                dm_rd_q    <= mem_rdata;
                                rd_valid_q <= 1'b1;
                            end
                        end
                    end else if (flush) begin
                        // The bus transaction stays outstanding; DRAIN absorbs its ack.
                        state_q <= S_DRAIN;
`ifdef DM_TIMEOUT_EN
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= S_IDLE;
                        mem_req_q  <= 1'b0;
                        exc_adel_q <= !we_q;
                        exc_ades_q <= we_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                S_DRAIN: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_IDLE;
`ifdef DM_TIMEOUT_EN
                    end else if (cnt_q == CNT_LAST) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = {addr_q[31:2], 2'b00};
    assign mem_byteen  = byteen_q;
    assign mem_wdata   = wdata_q;
    assign DM_RD       = dm_rd_q;
    assign DM_A        = dm_a_q;
    assign DM_Width_02 = dm_width_q;
    assign rd_valid    = rd_valid_q;
    assign exc_adel    = exc_adel_q;
    assign exc_ades    = exc_ades_q;

endmodule
